top_neurons: RTL and testbench

Single-clock array of NUM_NEURON binary stochastic-annealing neurons. It is loaded over a 16-bit word stream with per-neuron membrane potential, threshold and a ternary coupling row. It then anneals under a broadcast global threshold word and returns the spin vector on request. It sits between the chip I/O word bus and the host controller.

---
 rtl/top_neurons.sv | 127 ++++++++++++
 tb/tb_top_neurons.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_neurons.sv
// top_neurons: array of binary stochastic-annealing neurons, loaded over a 16-bit word stream,
// annealed one neuron per cycle under a broadcast global threshold, read back as 16-spin words.
module top_neurons #(
   parameter int FP_DATA_WIDTH   = 16,
   parameter int TEN_DATA_WIDTH  = 2,
   parameter int NUM_NEURON      = 256,
   parameter int NEURON_ID_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        rd,
   input  logic [15:0] ins,
   output logic [15:0] outs,
   output logic        readDone
);
   localparam int FW = FP_DATA_WIDTH;
   localparam int IW = NEURON_ID_WIDTH;
   localparam int NW = NEURON_ID_WIDTH + 1;
   localparam int WORDS = (NUM_NEURON + 15) / 16;
   localparam logic [15:0] NMAX = 16'(NUM_NEURON);
   typedef enum logic [2:0] {IDLE, SYNC, LOAD, RUN, READ} state_t;
   state_t state, state_nx;
   logic [FW-1:0] vmem [NUM_NEURON];
   logic [FW-1:0] mu [NUM_NEURON];
   logic [TEN_DATA_WIDTH-1:0] q [NUM_NEURON][NUM_NEURON];
   logic [NUM_NEURON-1:0] spin;
   logic [16*WORDS-1:0] spin_vec;
   logic [NW-1:0] n, r, c, nwords, widx;
   logic [IW-1:0] id, p, k;
   logic [FW-1:0] vm_in, mu_in, gmu, th;
   logic s_new, last_slot, last_rec, last_word, step;

   function automatic logic [FW-1:0] sat(input logic [FW-1:0] a, input logic [FW-1:0] b);
      logic [FW:0] s;
      s = {a[FW-1], a} + {b[FW-1], b};
      return (s[FW] != s[FW-1]) ? (s[FW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}}) : s[FW-1:0];
   endfunction

   function automatic logic [FW-1:0] weight(input logic [TEN_DATA_WIDTH-1:0] e, input logic s);
      logic [FW-1:0] w;
      w = (e == TEN_DATA_WIDTH'(1)) ? FW'(1) : (e == TEN_DATA_WIDTH'(2)) ? '1 : '0;
      return s ? w : -w;
   endfunction

   always_comb begin
      last_slot = c == n + NW'(7);
      last_rec = r == n - NW'(1);
      nwords = (n + NW'(15)) >> 4;
      last_word = widx == nwords - NW'(1);
      k = IW'(c - NW'(6));
      th = sat(mu[p], gmu);
      s_new = $signed(vmem[p]) >= $signed(th);
      step = state == RUN && !rd;
      spin_vec = '0;
      for (int j = 0; j < NUM_NEURON; j++) spin_vec[j] = spin[j] & (NW'(j) < n);
      state_nx = state;
      case (state)
         IDLE: state_nx = (ins != '0 && ins <= NMAX) ? SYNC : IDLE;
         SYNC: state_nx = (ins == 16'hFFFF) ? LOAD : IDLE;
         LOAD: state_nx = (last_slot && last_rec) ? RUN : LOAD;
         RUN:  state_nx = (rd && nwords != NW'(1)) ? READ : RUN;
         READ: state_nx = last_word ? RUN : READ;
         default: state_nx = IDLE;
      endcase
   end

   // Coupling RAM is deliberately left out of reset
   always_ff @(posedge clk)
      if (!reset_l && state == LOAD && c >= NW'(6) && c < n + NW'(6) && {1'b0, id} < n)
         q[id][k] <= ins[TEN_DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset_l) begin
         state <= IDLE;
         {n, r, c, widx} <= '0;
         {id, p} <= '0;
         {vm_in, mu_in, gmu} <= '0;
         spin <= '0;
         outs <= '0;
         readDone <= 1'b0;
         for (int j = 0; j < NUM_NEURON; j++) begin
            vmem[j] <= '0;
            mu[j] <= '0;
         end
      end else begin
         state <= state_nx;
         readDone <= 1'b0;
         if (state == IDLE && state_nx == SYNC) n <= ins[NW-1:0];
         if (state == SYNC) {c, r} <= '0;
         if (state == LOAD) begin
            c <= last_slot ? '0 : c + NW'(1);
            if (last_slot) r <= r + NW'(1);
            if (c == NW'(0)) vm_in <= ins;
            if (c == NW'(2)) mu_in <= ins;
            if (c == NW'(4)) begin
               id <= ins[IW-1:0];
               if ({1'b0, ins[IW-1:0]} < n) begin
                  vmem[ins[IW-1:0]] <= vm_in;
                  mu[ins[IW-1:0]] <= mu_in;
                  spin[ins[IW-1:0]] <= 1'b0;
               end
            end
            p <= '0;
         end
         if (step) begin
            gmu <= ins;
            p <= ({1'b0, p} == n - NW'(1)) ? '0 : p + IW'(1);
            // A flip of neuron p pushes its coupling column into every loaded neuron
            if (s_new != spin[p]) begin
               spin[p] <= s_new;
               for (int j = 0; j < NUM_NEURON; j++)
                  if (NW'(j) < n) vmem[j] <= sat(vmem[j], weight(q[j][p], s_new));
            end
         end
         if (state == RUN && rd) begin
            outs <= spin_vec[15:0];
            readDone <= nwords == NW'(1);
            widx <= NW'(1);
         end
         if (state == READ) begin
            outs <= spin_vec[{widx, 4'b0} +: 16];
            readDone <= last_word;
            widx <= widx + NW'(1);
         end
      end
   end
endmodule

// File: tb/tb_top_neurons.sv
// tb_top_neurons: table vectors, directed corner sequences and a randomized run against an integer model.
module tb_top_neurons;
   localparam int NN = 32;
   localparam int IDW = 5;
   logic clk = 1'b0;
   logic reset_l = 1'b1;
   logic rd = 1'b0;
   logic [15:0] ins = '0;
   logic [15:0] outs;
   logic readDone;
   always #5 clk = ~clk;

   top_neurons #(.NUM_NEURON(NN), .NEURON_ID_WIDTH(IDW)) dut (
      .clk(clk), .reset_l(reset_l), .rd(rd), .ins(ins), .outs(outs), .readDone(readDone));

   int total = 0, bad = 0;
   int m_vm[NN], m_mu[NN], m_q[NN][NN];
   bit m_sp[NN];
   int m_n, m_gmu, m_p, m_widx;
   bit m_reading;
   logic [15:0] m_outs;
   logic m_done;
   int r_vm[NN], r_mu[NN], r_id[NN], r_q[NN][NN];

   typedef struct {
      logic [15:0] cnt;
      logic [15:0] syn;
      logic exp_done;
      logic [15:0] exp_outs;
   } vec_t;
   vec_t vecs[7];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endfunction

   function automatic int sat(int v);
      return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
   endfunction

   function automatic int wdec(int e);
      return e == 1 ? 1 : e == 2 ? -1 : 0;
   endfunction

   function automatic logic [15:0] m_word(int i);
      logic [15:0] w = '0;
      for (int b = 0; b < 16; b++)
         if (16 * i + b < m_n && m_sp[16 * i + b]) w[b] = 1'b1;
      return w;
   endfunction

   task automatic m_step(input logic [15:0] w, input logic r);
      int nw, th, d;
      bit s;
      nw = (m_n + 15) / 16;
      if (m_reading) begin
         m_outs = m_word(m_widx);
         m_done = (m_widx == nw - 1);
         m_widx++;
         if (m_done) m_reading = 0;
      end else if (r) begin
         m_outs = m_word(0);
         m_done = (nw == 1);
         m_reading = !m_done;
         m_widx = 1;
      end else begin
         m_done = 0;
         th = sat(m_mu[m_p] + m_gmu);
         s = m_vm[m_p] >= th;
         if (s != m_sp[m_p]) begin
            m_sp[m_p] = s;
            for (int j = 0; j < m_n; j++) begin
               d = wdec(m_q[j][m_p]);
               m_vm[j] = sat(m_vm[j] + (s ? d : -d));
            end
         end
         m_gmu = int'($signed(w));
         m_p = (m_p + 1) % m_n;
      end
   endtask

   task automatic tick(input logic [15:0] w, input logic r);
      ins = w;
      rd = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_l = 1'b1;
      rd = 1'b0;
      ins = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_l = 1'b0;
      for (int j = 0; j < NN; j++) begin
         m_vm[j] = 0;
         m_mu[j] = 0;
         m_sp[j] = 0;
      end
      m_n = 1; m_gmu = 0; m_p = 0; m_widx = 0; m_reading = 0;
      m_outs = '0; m_done = 1'b0;
   endtask

   task automatic load(input int n);
      logic [15:0] junk, w;
      tick(16'(n), 1'b0);
      tick(16'hFFFF, 1'b0);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n + 8; c++) begin
            junk = 16'($urandom);
            w = c == 0 ? 16'(r_vm[r]) : c == 2 ? 16'(r_mu[r]) : c == 4 ? 16'(r_id[r]) :
                (c >= 6 && c < n + 6) ? {junk[15:2], 2'(r_q[r][c - 6])} : junk;
            tick(w, 1'b0);
         end
      m_n = n;
      m_p = 0;
      for (int r = 0; r < n; r++)
         if (r_id[r] < n) begin
            m_vm[r_id[r]] = r_vm[r];
            m_mu[r_id[r]] = r_mu[r];
            m_sp[r_id[r]] = 0;
            for (int k = 0; k < n; k++) m_q[r_id[r]][k] = r_q[r][k];
         end
   endtask

   task automatic one_rec_stream();
      tick(16'h7000, 0); tick(16'h7777, 0); tick(16'h8000, 0); tick(16'h7777, 0);
      tick(16'h0000, 0); tick(16'h7777, 0); tick(16'h0001, 0); tick(16'h7777, 0);
      tick(16'h7777, 0);
   endtask

   task automatic set_n2();
      r_vm[0] = 5; r_mu[0] = 0; r_id[0] = 0; r_q[0][0] = 0; r_q[0][1] = 1;
      r_vm[1] = -3; r_mu[1] = 0; r_id[1] = 1; r_q[1][0] = 1; r_q[1][1] = 0;
   endtask

   initial begin
      logic [15:0] w;
      logic r, got_done;
      int n, t;
      vecs[0] = '{16'd1, 16'hFFFF, 1'b1, 16'h0001};
      vecs[1] = '{16'd2, 16'hFFFF, 1'b0, 16'h0000};
      vecs[2] = '{16'd0, 16'hFFFF, 1'b0, 16'h0000};
      vecs[3] = '{16'(NN + 1), 16'hFFFF, 1'b0, 16'h0000};
      vecs[4] = '{16'd2, 16'h1234, 1'b0, 16'h0000};
      vecs[5] = '{16'd1, 16'hFFFE, 1'b0, 16'h0000};
      vecs[6] = '{16'(NN), 16'hFFFF, 1'b0, 16'h0000};

      do_reset();
      chk("reset_outs", outs, 16'h0);
      chk("reset_done", readDone, 1'b0);

      foreach (vecs[i]) begin
         do_reset();
         tick(vecs[i].cnt, 0);
         tick(vecs[i].syn, 0);
         one_rec_stream();
         tick(16'h0, 0);
         tick(16'h0, 1);
         got_done = readDone;
         tick(16'h0, 0);
         chk($sformatf("vec%0d_done", i), got_done, vecs[i].exp_done);
         chk($sformatf("vec%0d_outs", i), outs, vecs[i].exp_outs);
      end

      do_reset();
      tick(16'd3, 0); tick(16'hFFFF, 0);
      repeat (5) tick(16'h0005, 0);
      reset_l = 1'b1; @(posedge clk); #1; reset_l = 1'b0;
      tick(16'hFFFF, 0);
      one_rec_stream();
      tick(16'h0, 0);
      tick(16'h0, 1);
      chk("midreset_done", readDone, 1'b0);
      chk("midreset_outs", outs, 16'h0);

      do_reset();
      for (int i = 0; i < 10; i++) begin
         r_vm[i] = 100 + i; r_mu[i] = -3 * i; r_id[i] = i;
         for (int k = 0; k < 10; k++) r_q[i][k] = (i + k) % 4;
      end
      load(10);
      chk("ld_vmem3", dut.vmem[3], 16'd103);
      chk("ld_mu3", dut.mu[3], 16'hFFF7);
      for (int k = 0; k < 10; k++) chk($sformatf("ld_q3_%0d", k), dut.q[3][k], (3 + k) % 4);

      do_reset();
      set_n2();
      load(2);
      tick(16'h0, 0);
      chk("ann_spin_c1", dut.spin[1:0], 2'b01);
      chk("ann_vmem1_c1", dut.vmem[1], 16'hFFFE);
      tick(16'h0, 0);
      chk("ann_spin_c2", dut.spin[1:0], 2'b01);
      tick(16'h0, 1);
      chk("ann_outs", outs, 16'h0001);
      chk("ann_done", readDone, 1'b1);
      tick(16'h0, 0);
      chk("ann_done_pulse", readDone, 1'b0);
      chk("ann_outs_hold", outs, 16'h0001);

      do_reset();
      set_n2();
      load(2);
      repeat (6) tick(16'h0010, 0);
      tick(16'h0010, 1);
      chk("thr_outs", outs, 16'h0000);
      chk("thr_vmem1", dut.vmem[1], 16'hFFFD);

      do_reset();
      r_vm[0] = 32767; r_mu[0] = -5; r_id[0] = 0; r_q[0][0] = 1;
      load(1);
      tick(16'h0, 0);
      chk("sat_spin", dut.spin[0], 1'b1);
      chk("sat_vmem", dut.vmem[0], 16'h7FFF);
      repeat (2) tick(16'h0, 0);
      chk("sat_vmem_hold", dut.vmem[0], 16'h7FFF);

      do_reset();
      for (int i = 0; i < 20; i++) begin
         r_vm[i] = 10; r_mu[i] = 0; r_id[i] = i;
         for (int k = 0; k < 20; k++) r_q[i][k] = 0;
      end
      load(20);
      repeat (5) tick(16'h0, 0);
      tick(16'h0, 1);
      chk("mw_w0", outs, 16'h001F);
      chk("mw_w0_done", readDone, 1'b0);
      tick(16'h0, 1);
      chk("mw_w1", outs, 16'h0000);
      chk("mw_w1_done", readDone, 1'b1);
      chk("mw_frozen", dut.spin[19:0], 20'h0001F);
      repeat (3) tick(16'h0, 0);
      chk("mw_after_done", readDone, 1'b0);
      tick(16'h0, 1);
      chk("mw_resume", outs, 16'h00FF);

      for (int it = 0; it < 6; it++) begin
         do_reset();
         n = (it == 0) ? 1 : (it == 1) ? NN : $urandom_range(2, NN);
         for (int i = 0; i < n; i++) r_id[i] = i;
         for (int i = n - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            t = r_id[i]; r_id[i] = r_id[j]; r_id[j] = t;
         end
         for (int i = 0; i < n; i++) begin
            t = $urandom_range(0, 9);
            r_vm[i] = t == 0 ? 32767 - $urandom_range(0, 2) : t == 1 ? -32768 + $urandom_range(0, 2) :
                      $urandom_range(0, 80) - 40;
            r_mu[i] = $urandom_range(0, 60) - 30;
            for (int k = 0; k < n; k++) r_q[i][k] = $urandom_range(0, 3);
         end
         load(n);
         for (int cyc = 0; cyc < 150; cyc++) begin
            w = ($urandom_range(0, 15) == 0) ? 16'h7FF0 : 16'($urandom_range(0, 40) - 20);
            r = $urandom_range(0, 9) == 0;
            ins = w;
            rd = r;
            @(posedge clk);
            m_step(w, r);
            #1;
            chk("rand_outs", outs, m_outs);
            chk("rand_done", readDone, m_done);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
